// File: rtl/pf_pkg.sv
// Shared types and constants for the frame buffer read path.
package pf_pkg;

    localparam int unsigned FIFO_RD_LATENCY = 1;
    localparam int unsigned SKID_DEPTH      = 2;
    localparam int unsigned BEAT_DATA_W     = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        STREAM = 2'd2,
        DONE   = 2'd3
    } egress_rd_state_t;

    // One egress beat: payload word plus end-of-frame marker.
    typedef struct packed {
        logic [BEAT_DATA_W-1:0] data;
        logic                   last;
    } egress_beat_t;

endpackage

// File: rtl/egress_skid_buffer.sv
// Two-entry valid/ready buffer with fall-through when empty and a synchronous flush.
import pf_pkg::*;

module egress_skid_buffer (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         in_valid,
    input  egress_beat_t in_beat,
    output logic         out_valid,
    output egress_beat_t out_beat,
    input  logic         out_ready,
    output logic [1:0]   occupancy
);

    logic [1:0]   count;
    egress_beat_t ent0;
    egress_beat_t ent1;
    logic         pop;

    assign occupancy = count;
    assign out_valid = (count != 2'd0) | in_valid;
    assign pop       = out_valid & out_ready;

    // Head is the oldest stored entry; an arriving word passes straight through when empty.
    always_comb begin
        out_beat = '0;
        if (count != 2'd0) begin
            out_beat = ent0;
        end else if (in_valid) begin
            out_beat = in_beat;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= 2'd0;
            ent0  <= '0;
            ent1  <= '0;
        end else if (flush) begin
            count <= 2'd0;
        end else begin
            case (count)
                2'd0: begin
                    if (in_valid && !out_ready) begin
                        ent0  <= in_beat;
                        count <= 2'd1;
                    end
                end
                2'd1: begin
                    if (pop && in_valid) begin
                        ent0 <= in_beat;
                    end else if (pop) begin
                        count <= 2'd0;
                    end else if (in_valid) begin
                        ent1  <= in_beat;
                        count <= 2'd2;
                    end
                end
                2'd2: begin
                    if (pop) begin
                        ent0 <= ent1;
                        if (in_valid) begin
                            ent1 <= in_beat;
                        end else begin
                            count <= 2'd1;
                        end
                    end
                end
                default: count <= 2'd0;
            endcase
        end
    end

endmodule

// File: rtl/frame_egress_reader.sv
// Rewinds the frame FIFO read pointer to a stored frame and streams its words out
// as a valid/ready stream with tlast, absorbing read latency and back-pressure.
import pf_pkg::*;

module frame_egress_reader #(
    parameter int unsigned ADDR_WIDTH = 11
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH:0]   cmd_base_ptr,
    input  logic [ADDR_WIDTH:0]   cmd_len,
    input  logic                  abort,
    output logic                  frame_ren,
    output logic                  frame_rrst,
    output logic [ADDR_WIDTH:0]   frame_rst_rptr,
    input  logic [19:0]           frame_rdata,
    output logic                  egress_tvalid,
    output logic [15:0]           egress_tdata,
    output logic                  egress_tlast,
    input  logic                  egress_tready,
    output logic                  frame_done,
    output logic                  busy
);

    localparam int unsigned PW = ADDR_WIDTH + 1;

    egress_rd_state_t            state;
    logic [PW-1:0]               len_q;
    logic [PW-1:0]               issued;
    logic [PW-1:0]               sent;
    logic [FIFO_RD_LATENCY-1:0]  ren_pipe;
    logic [FIFO_RD_LATENCY-1:0]  last_pipe;
    logic                        inflight;
    logic                        inflight_last;
    logic [1:0]                  occupancy;
    logic                        room;
    logic                        issue_last;
    logic                        beat_fire;
    logic                        stream_abort;
    egress_beat_t                wr_beat;
    egress_beat_t                head_beat;
    logic                        unused_rdata_hi;

    assign inflight      = ren_pipe[FIFO_RD_LATENCY-1];
    assign inflight_last = last_pipe[FIFO_RD_LATENCY-1];

    // Never request a word unless the buffer can hold it together with whatever is already in flight.
    assign room         = (3'(occupancy) + 3'(inflight)) < 3'(SKID_DEPTH);
    assign frame_ren    = (state == STREAM) && (issued < len_q) && room;
    assign issue_last   = (issued == (len_q - PW'(1)));
    assign beat_fire    = egress_tvalid & egress_tready;
    assign stream_abort = abort && ((state == LOAD) || (state == STREAM));

    assign wr_beat.data    = frame_rdata[15:0];
    assign wr_beat.last    = inflight_last;
    assign unused_rdata_hi = ^frame_rdata[19:16];

    egress_skid_buffer u_skid (
        .clk       (clk),
        .reset     (reset),
        .flush     (stream_abort),
        .in_valid  (inflight),
        .in_beat   (wr_beat),
        .out_valid (egress_tvalid),
        .out_beat  (head_beat),
        .out_ready (egress_tready),
        .occupancy (occupancy)
    );

    assign egress_tdata = head_beat.data;
    assign egress_tlast = head_beat.last;

    // Control FSM, counters and registered handshake/status outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            len_q          <= '0;
            issued         <= '0;
            sent           <= '0;
            ren_pipe       <= '0;
            last_pipe      <= '0;
            cmd_ready      <= 1'b1;
            busy           <= 1'b0;
            frame_rrst     <= 1'b0;
            frame_rst_rptr <= '0;
            frame_done     <= 1'b0;
        end else begin
            frame_rrst <= 1'b0;
            frame_done <= 1'b0;
            ren_pipe   <= FIFO_RD_LATENCY'({ren_pipe, frame_ren});
            last_pipe  <= FIFO_RD_LATENCY'({last_pipe, frame_ren & issue_last});
            if (frame_ren) begin
                issued <= issued + PW'(1);
            end
            if (beat_fire) begin
                sent <= sent + PW'(1);
            end

            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        len_q     <= cmd_len;
                        issued    <= '0;
                        sent      <= '0;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        if (cmd_len == '0) begin
                            state      <= DONE;
                            frame_done <= 1'b1;
                        end else begin
                            state          <= LOAD;
                            frame_rrst     <= 1'b1;
                            frame_rst_rptr <= cmd_base_ptr;
                        end
                    end
                end
                LOAD: begin
                    if (abort) begin
                        state      <= DONE;
                        frame_done <= 1'b1;
                    end else begin
                        state <= STREAM;
                    end
                end
                STREAM: begin
                    if (abort) begin
                        state      <= DONE;
                        frame_done <= 1'b1;
                        ren_pipe   <= '0;
                        last_pipe  <= '0;
                    end else if (beat_fire && (sent == (len_q - PW'(1)))) begin
                        state      <= DONE;
                        frame_done <= 1'b1;
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    cmd_ready <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_frame_egress_reader.sv
// Scoreboard bench for frame_egress_reader with a behavioural one-cycle-latency FIFO.
module tb_frame_egress_reader;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [11:0] cmd_base_ptr;
    logic [11:0] cmd_len;
    logic        abort;
    logic        frame_ren;
    logic        frame_rrst;
    logic [11:0] frame_rst_rptr;
    logic [19:0] frame_rdata = '0;
    logic        egress_tvalid;
    logic [15:0] egress_tdata;
    logic        egress_tlast;
    logic        egress_tready = 1'b1;
    logic        frame_done;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [16:0] sb[$];

    frame_egress_reader #(.ADDR_WIDTH(11)) dut (
        .clk            (clk),
        .reset          (reset),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_base_ptr   (cmd_base_ptr),
        .cmd_len        (cmd_len),
        .abort          (abort),
        .frame_ren      (frame_ren),
        .frame_rrst     (frame_rrst),
        .frame_rst_rptr (frame_rst_rptr),
        .frame_rdata    (frame_rdata),
        .egress_tvalid  (egress_tvalid),
        .egress_tdata   (egress_tdata),
        .egress_tlast   (egress_tlast),
        .egress_tready  (egress_tready),
        .frame_done     (frame_done),
        .busy           (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // FIFO content: upper nibble is noise the DUT must ignore.
    function automatic logic [19:0] fifo_word(input logic [11:0] a);
        logic [15:0] d;
        d = {a[3:0], a} ^ 16'h5A3C;
        return {a[11:8] ^ 4'hF, d};
    endfunction

    logic [11:0] rptr_m = '0;
    always @(posedge clk) begin
        if (frame_rrst) begin
            rptr_m <= frame_rst_rptr;
        end else if (frame_ren) begin
            frame_rdata <= fifo_word(rptr_m);
            rptr_m      <= rptr_m + 12'd1;
        end
    end

    // Back-pressure generator: 0 = always ready, 1 = pattern 1,0,0,1, 2 = never ready.
    int tready_mode = 0;
    int ph = 0;
    always @(posedge clk) begin
        #2;
        case (tready_mode)
            1:       egress_tready = (ph == 0) || (ph == 3);
            2:       egress_tready = 1'b0;
            default: egress_tready = 1'b1;
        endcase
        ph = (ph + 1) % 4;
    end

    int beat_cnt, ren_cnt, rrst_cnt, tvalid_cnt, tlast_cnt, done_cnt, acc_cnt;
    int acc_cyc, first_ren_cyc, first_valid_cyc, last_cyc, done_cyc, ready_cyc, abort_cyc, rrst_cyc;
    int held, max_held;
    logic [11:0] rrst_ptr;
    logic        prev_stall = 1'b0;
    logic        prev_abort = 1'b0;
    logic [15:0] prev_data  = '0;

    task automatic clear_stats();
        beat_cnt = 0; ren_cnt = 0; rrst_cnt = 0; tvalid_cnt = 0; tlast_cnt = 0;
        done_cnt = 0; acc_cnt = 0; max_held = 0;
        acc_cyc = -1; first_ren_cyc = -1; first_valid_cyc = -1; last_cyc = -1;
        done_cyc = -1; ready_cyc = -1; abort_cyc = -1; rrst_cyc = -1;
        rrst_ptr = '0;
    endtask

    // Output monitor: scoreboard pop on every handshake plus event timestamps.
    always @(negedge clk) begin
        logic [16:0] exp_beat;
        if (!reset) begin
            prev_stall = 1'b0;
            prev_abort = 1'b0;
        end else begin
            held = ren_cnt - beat_cnt;
            if (held > max_held) max_held = held;
            if (cmd_valid && cmd_ready) begin acc_cnt++; acc_cyc = cyc; end
            if (frame_rrst) begin rrst_cnt++; rrst_cyc = cyc; rrst_ptr = frame_rst_rptr; end
            if (frame_ren) begin
                if (ren_cnt == 0) first_ren_cyc = cyc;
                ren_cnt++;
            end
            if (egress_tvalid) begin
                if (tvalid_cnt == 0) first_valid_cyc = cyc;
                tvalid_cnt++;
            end
            if (prev_stall && !prev_abort) begin
                chk("stall_valid", 32'(egress_tvalid), 32'd1);
                chk("stall_data", 32'(egress_tdata), 32'(prev_data));
            end
            if (egress_tvalid && egress_tready) begin
                beat_cnt++;
                if (egress_tlast) begin tlast_cnt++; last_cyc = cyc; end
                chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    exp_beat = sb.pop_front();
                    chk("beat", 32'({egress_tdata, egress_tlast}), 32'(exp_beat));
                end
            end
            if (frame_done) begin done_cnt++; done_cyc = cyc; end
            if (done_cnt > 0 && ready_cyc < 0 && cmd_ready) ready_cyc = cyc;
            if (abort) abort_cyc = cyc;
            prev_stall = egress_tvalid && !egress_tready;
            prev_abort = abort;
            prev_data  = egress_tdata;
        end
    end

    task automatic push_frame(input logic [11:0] base, input logic [11:0] len);
        logic [19:0] w;
        logic [11:0] a;
        for (int i = 0; i < int'(len); i++) begin
            a = base + 12'(i);
            w = fifo_word(a);
            sb.push_back({w[15:0], (i == int'(len) - 1)});
        end
    endtask

    task automatic send_cmd(input logic [11:0] base, input logic [11:0] len);
        int n = 0;
        push_frame(base, len);
        while (!cmd_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("cmd_ready_wait", 32'(cmd_ready), 32'd1);
        cmd_base_ptr = base;
        cmd_len      = len;
        cmd_valid    = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc);
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk); #1;
            if (done_cnt > 0) break;
        end
        chk("done_seen", 32'(done_cnt != 0), 32'd1);
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout at cycle %0d", cyc);
        $fatal(1, "bench time limit");
    end

    initial begin
        reset        = 1'b0;
        cmd_valid    = 1'b0;
        cmd_base_ptr = '0;
        cmd_len      = '0;
        abort        = 1'b0;
        clear_stats();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_tvalid", 32'(egress_tvalid), 32'd0);
        chk("rst_ren", 32'(frame_ren), 32'd0);
        chk("rst_rrst", 32'(frame_rrst), 32'd0);
        chk("rst_done", 32'(frame_done), 32'd0);
        chk("rst_rptr", 32'(frame_rst_rptr), 32'd0);
        chk("rst_tdata", 32'(egress_tdata), 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Basic frame with exact latency checks.
        clear_stats();
        send_cmd(12'h010, 12'd4);
        wait_done(40);
        repeat (3) @(posedge clk);
        #1;
        chk("t1_rptr", 32'(rrst_ptr), 32'h010);
        chk("t1_rrst_cnt", 32'(rrst_cnt), 32'd1);
        chk("t1_rrst_lat", 32'(rrst_cyc - acc_cyc), 32'd1);
        chk("t1_ren_lat", 32'(first_ren_cyc - acc_cyc), 32'd2);
        chk("t1_valid_lat", 32'(first_valid_cyc - acc_cyc), 32'd3);
        chk("t1_last_lat", 32'(last_cyc - acc_cyc), 32'd6);
        chk("t1_done_lat", 32'(done_cyc - last_cyc), 32'd1);
        chk("t1_ready_lat", 32'(ready_cyc - done_cyc), 32'd1);
        chk("t1_beats", 32'(beat_cnt), 32'd4);
        chk("t1_tlast", 32'(tlast_cnt), 32'd1);
        chk("t1_sb_empty", 32'(sb.size()), 32'd0);

        // Cursor wrap at the top of the address space.
        clear_stats();
        send_cmd(12'hFFE, 12'd5);
        wait_done(40);
        repeat (2) @(posedge clk);
        #1;
        chk("t2_rptr", 32'(rrst_ptr), 32'hFFE);
        chk("t2_beats", 32'(beat_cnt), 32'd5);
        chk("t2_tlast", 32'(tlast_cnt), 32'd1);
        chk("t2_sb_empty", 32'(sb.size()), 32'd0);

        // Back-pressure, plus a command offered while busy that must be ignored.
        clear_stats();
        tready_mode = 1;
        send_cmd(12'h200, 12'd8);
        cmd_len   = 12'd5;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        wait_done(100);
        tready_mode = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("t3_beats", 32'(beat_cnt), 32'd8);
        chk("t3_tlast", 32'(tlast_cnt), 32'd1);
        chk("t3_sb_empty", 32'(sb.size()), 32'd0);
        chk("t3_accepts", 32'(acc_cnt), 32'd1);
        chk("t3_max_held", 32'(max_held <= 2), 32'd1);

        // Zero-length frame.
        clear_stats();
        send_cmd(12'h040, 12'd0);
        wait_done(20);
        repeat (3) @(posedge clk);
        #1;
        chk("t4_done_cnt", 32'(done_cnt), 32'd1);
        chk("t4_done_lat", 32'(done_cyc - acc_cyc), 32'd1);
        chk("t4_ready_lat", 32'(ready_cyc - acc_cyc), 32'd2);
        chk("t4_rrst_cnt", 32'(rrst_cnt), 32'd0);
        chk("t4_ren_cnt", 32'(ren_cnt), 32'd0);
        chk("t4_tvalid_cnt", 32'(tvalid_cnt), 32'd0);

        // Abort after the tenth beat, then a clean follow-up frame.
        clear_stats();
        send_cmd(12'h300, 12'd100);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk); #1;
            if (beat_cnt >= 10) break;
        end
        chk("t5_reach10", 32'(beat_cnt), 32'd10);
        @(posedge clk); #1;
        abort       = 1'b1;
        tready_mode = 2;
        @(posedge clk); #1;
        abort       = 1'b0;
        tready_mode = 0;
        @(negedge clk);
        chk("t5_tvalid_off", 32'(egress_tvalid), 32'd0);
        sb.delete();
        wait_done(10);
        repeat (3) @(posedge clk);
        #1;
        chk("t5_beats", 32'(beat_cnt), 32'd10);
        chk("t5_tlast", 32'(tlast_cnt), 32'd0);
        chk("t5_done_cnt", 32'(done_cnt), 32'd1);
        chk("t5_done_lat", 32'((done_cyc - abort_cyc >= 1) && (done_cyc - abort_cyc <= 2)), 32'd1);
        chk("t5_cmd_ready", 32'(cmd_ready), 32'd1);
        clear_stats();
        send_cmd(12'h400, 12'd6);
        wait_done(40);
        repeat (2) @(posedge clk);
        #1;
        chk("t5b_rptr", 32'(rrst_ptr), 32'h400);
        chk("t5b_beats", 32'(beat_cnt), 32'd6);
        chk("t5b_tlast", 32'(tlast_cnt), 32'd1);
        chk("t5b_sb_empty", 32'(sb.size()), 32'd0);

        // Asynchronous reset in the middle of a long frame.
        clear_stats();
        send_cmd(12'h500, 12'd100);
        repeat (20) @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        chk("t6_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_tvalid", 32'(egress_tvalid), 32'd0);
        chk("t6_ren", 32'(frame_ren), 32'd0);
        chk("t6_rrst", 32'(frame_rrst), 32'd0);
        chk("t6_done", 32'(frame_done), 32'd0);
        chk("t6_tlast", 32'(egress_tlast), 32'd0);
        chk("t6_rptr", 32'(frame_rst_rptr), 32'd0);
        chk("t6_tdata", 32'(egress_tdata), 32'd0);
        sb.delete();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        clear_stats();
        send_cmd(12'hA00, 12'd3);
        wait_done(40);
        repeat (2) @(posedge clk);
        #1;
        chk("t6b_rptr", 32'(rrst_ptr), 32'hA00);
        chk("t6b_beats", 32'(beat_cnt), 32'd3);
        chk("t6b_tlast", 32'(tlast_cnt), 32'd1);
        chk("t6b_sb_empty", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
